// File: rtl/mux_io_ic_pkg.sv
// mux_io_ic_pkg: shared helpers and constants for the IO interconnect mux.
// Defining MUX_IO_IC_PARITY_EN appends an even-parity bit to the config chain.
package mux_io_ic_pkg;
`ifdef MUX_IO_IC_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif
    localparam logic RST_VAL = 1'b0;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int chain_w(input int sel_w);
        return sel_w + PARITY_W;
    endfunction
endpackage

// File: rtl/mux_io_ic_level.sv
// mux_io_ic_level: one level of the mux tree; halves its input vector by one
// selector bit and optionally registers data, remaining selector bits and valid.
module mux_io_ic_level
    import mux_io_ic_pkg::*;
#(
    parameter int IN_W       = 2,
    parameter int SEL_W      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   data_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              valid_i,
    output logic [IN_W/2-1:0] data_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              valid_o
);
    localparam int H = IN_W / 2;
    localparam int B = clog2(IN_W) - 1;
    localparam logic [SEL_W-1:0] KEEP = SEL_W'((1 << B) - 1);
    logic [H-1:0]     data_d;
    logic [SEL_W-1:0] sel_d;
    assign data_d = sel_i[B] ? data_i[IN_W-1:H] : data_i[H-1:0];
    // Consumed bits are cleared so only the bits later levels still need travel on.
    assign sel_d = sel_i & KEEP;
    if (REGISTERED) begin : g_reg
        logic [H-1:0]     data_q;
        logic [SEL_W-1:0] sel_q;
        logic             valid_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= {H{RST_VAL}};
                sel_q   <= {SEL_W{RST_VAL}};
                valid_q <= RST_VAL;
            end else begin
                data_q  <= data_d;
                sel_q   <= sel_d;
                valid_q <= valid_i;
            end
        end
        assign data_o  = data_q;
        assign sel_o   = sel_q;
        assign valid_o = valid_q;
    end else begin : g_comb
        assign data_o  = data_d;
        assign sel_o   = sel_d;
        assign valid_o = valid_i;
    end
endmodule

// File: rtl/multiplexer_io_ic_pipe.sv
// multiplexer_io_ic_pipe: N:1 IO interconnect mux with a serially loaded,
// atomically committed selector; MUX_IO_IC_PARITY_EN enables chain parity.
module multiplexer_io_ic_pipe
    import mux_io_ic_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int PIPELINED = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] data_in,
    input  logic                data_valid_in,
    output logic                data_out,
    output logic                data_valid_out,
    input  logic                config_en,
    input  logic                config_in,
    output logic                config_out,
    input  logic                config_latch,
    output logic                config_err
);
    localparam int SEL_W = clog2(N_INPUTS);
    localparam int CW    = chain_w(SEL_W);
    logic [CW-1:0]         shadow_q;
    logic [SEL_W-1:0]      sel_q;
    logic [2*N_INPUTS-2:0] tree;
    logic [SEL_W-1:0]      sel_s [0:SEL_W];
    logic [SEL_W:0]        vld;
`ifdef MUX_IO_IC_PARITY_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {CW{RST_VAL}};
            sel_q    <= {SEL_W{RST_VAL}};
            err_q    <= RST_VAL;
        end else if (config_en) begin
            shadow_q <= CW'({shadow_q, config_in});
        end else if (config_latch) begin
            // A word with odd parity is rejected and the old routing stays live.
            if (^shadow_q) begin
                err_q <= 1'b1;
            end else begin
                sel_q <= shadow_q[CW-1:1];
                err_q <= 1'b0;
            end
        end
    end
    assign config_err = err_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {CW{RST_VAL}};
            sel_q    <= {SEL_W{RST_VAL}};
        end else if (config_en) begin
            shadow_q <= CW'({shadow_q, config_in});
        end else if (config_latch) begin
            sel_q <= shadow_q;
        end
    end
    assign config_err = 1'b0;
`endif
    assign config_out = shadow_q[CW-1];
    // Tree levels are packed back to back: level k's input starts at 2N - 2*(N>>k).
    assign tree[N_INPUTS-1:0] = data_in;
    assign sel_s[0] = sel_q;
    assign vld[0]   = data_valid_in;
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int W  = N_INPUTS >> k;
        localparam int OI = 2 * N_INPUTS - 2 * W;
        localparam int OO = OI + W;
        mux_io_ic_level #(
            .IN_W      (W),
            .SEL_W     (SEL_W),
            .REGISTERED(PIPELINED != 0)
        ) u_lvl (
            .clk    (clk),
            .rst_n  (rst_n),
            .data_i (tree[OI +: W]),
            .sel_i  (sel_s[k]),
            .valid_i(vld[k]),
            .data_o (tree[OO +: W/2]),
            .sel_o  (sel_s[k+1]),
            .valid_o(vld[k+1])
        );
    end
    assign data_out       = tree[2*N_INPUTS-2];
    assign data_valid_out = vld[SEL_W];
endmodule

// File: tb/tb_multiplexer_io_ic_pipe.sv
// tb_multiplexer_io_ic_pipe: directed bench for the 16:1 pipelined IO mux;
// follows MUX_IO_IC_PARITY_EN for the chain word format.
module tb_multiplexer_io_ic_pipe;
`ifdef MUX_IO_IC_PARITY_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid_in;
    logic        data_out;
    logic        data_valid_out;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic        config_latch;
    logic        config_err;
    int          nvec = 0;
    int          nerr = 0;

    multiplexer_io_ic_pipe #(.N_INPUTS(16), .PIPELINED(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .config_en     (config_en),
        .config_in     (config_in),
        .config_out    (config_out),
        .config_latch  (config_latch),
        .config_err    (config_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] word(input logic [3:0] s);
`ifdef MUX_IO_IC_PARITY_EN
        return {s, ^s};
`else
        return s;
`endif
    endfunction

    task automatic shift_word(input logic [CW-1:0] w);
        for (int i = CW - 1; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = w[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic commit();
        config_latch = 1'b1;
        tick();
        config_latch = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data_in = 16'($urandom);
        data_valid_in = 1'b1;
        tick(3);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL reset_data: got %b want 0", data_out); end
        nvec++; if (data_valid_out !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", data_valid_out); end
        nvec++; if (config_out !== 1'b0) begin nerr++; $display("FAIL reset_cfg_out: got %b want 0", config_out); end
        nvec++; if (config_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", config_err); end
        rst_n = 1'b1;
        data_in = 16'h0001;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL reset_sel0_hi: got %b want 1", data_out); end
        nvec++; if (data_valid_out !== 1'b1) begin nerr++; $display("FAIL reset_sel0_valid: got %b want 1", data_valid_out); end
        data_in = 16'hFFFE;
        tick(4);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL reset_sel0_lo: got %b want 0", data_out); end
    endtask

    task automatic test_load_commit();
        data_in = 16'h0000;
        shift_word(word(4'b1011));
        commit();
        data_in = 16'h0800;
        data_valid_in = 1'b1;
        tick(3);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL load_early: got %b want 0", data_out); end
        tick();
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL load_data: got %b want 1", data_out); end
        nvec++; if (data_valid_out !== 1'b1) begin nerr++; $display("FAIL load_valid: got %b want 1", data_valid_out); end
        data_in = 16'hF7FF;
        data_valid_in = 1'b0;
        tick(4);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL load_inv_data: got %b want 0", data_out); end
        nvec++; if (data_valid_out !== 1'b0) begin nerr++; $display("FAIL load_invalid: got %b want 0", data_valid_out); end
        data_in = 16'h0800;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL load_ungated: got %b want 1", data_out); end
        data_valid_in = 1'b1;
    endtask

    task automatic test_commit_streaming();
        logic [3:0] msel;
        logic       expq [0:15];
        shift_word(word(4'd3));
        commit();
        shift_word(word(4'd12));
        msel = 4'd3;
        for (int j = 0; j < 16; j++) begin
            data_in = (j % 2 == 0) ? 16'h0008 : 16'h1000;
            config_latch = (j == 6);
            expq[j] = data_in[msel];
            tick();
            if (j == 6) msel = 4'd12;
            config_latch = 1'b0;
            if (j >= 3) begin
                nvec++;
                if (data_out !== expq[j-3]) begin
                    nerr++;
                    $display("FAIL stream_s%0d: got %b want %b", j - 3, data_out, expq[j-3]);
                end
            end
        end
    endtask

    task automatic test_chain();
        logic [2*CW-1:0] s;
        s = {word(4'b0110), word(4'b0101)};
        nvec++; if (config_out !== 1'b1) begin nerr++; $display("FAIL chain_old_msb: got %b want 1", config_out); end
        config_en = 1'b1;
        config_latch = 1'b1;
        for (int k = 1; k <= 2 * CW; k++) begin
            config_in = s[2*CW-k];
            tick();
            if (k >= CW && k < 2 * CW) begin
                nvec++;
                if (config_out !== s[3*CW-1-k]) begin
                    nerr++;
                    $display("FAIL chain_bit%0d: got %b want %b", k - CW, config_out, s[3*CW-1-k]);
                end
            end
        end
        config_en = 1'b0;
        config_latch = 1'b0;
        config_in = 1'b0;
        data_in = 16'h1000;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL chain_latch_ignored: got %b want 1", data_out); end
        data_in = 16'h0020;
        commit();
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL chain_commit_new: got %b want 1", data_out); end
        data_in = 16'h1000;
        tick(4);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL chain_old_sel_gone: got %b want 0", data_out); end
    endtask

    task automatic test_parity();
`ifdef MUX_IO_IC_PARITY_EN
        shift_word({4'd9, ~(^4'd9)});
        commit();
        nvec++; if (config_err !== 1'b1) begin nerr++; $display("FAIL parity_bad_err: got %b want 1", config_err); end
        data_in = 16'h0020;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL parity_sel_kept: got %b want 1", data_out); end
        tick(2);
        nvec++; if (config_err !== 1'b1) begin nerr++; $display("FAIL parity_sticky: got %b want 1", config_err); end
`endif
        shift_word(word(4'd9));
        commit();
        nvec++; if (config_err !== 1'b0) begin nerr++; $display("FAIL parity_good_err: got %b want 0", config_err); end
        data_in = 16'h0200;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL parity_sel_new: got %b want 1", data_out); end
    endtask

    task automatic test_reset_mid();
        data_in = 16'hFFFF;
        data_valid_in = 1'b1;
        tick(5);
        config_en = 1'b1;
        config_in = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL rmid_data: got %b want 0", data_out); end
        nvec++; if (data_valid_out !== 1'b0) begin nerr++; $display("FAIL rmid_valid: got %b want 0", data_valid_out); end
        nvec++; if (config_out !== 1'b0) begin nerr++; $display("FAIL rmid_cfg_out: got %b want 0", config_out); end
        nvec++; if (config_err !== 1'b0) begin nerr++; $display("FAIL rmid_err: got %b want 0", config_err); end
        config_en = 1'b0;
        config_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        config_en = 1'b1;
        for (int k = 0; k < CW; k++) begin
            nvec++;
            if (config_out !== 1'b0) begin nerr++; $display("FAIL rmid_shadow%0d: got %b want 0", k, config_out); end
            tick();
        end
        config_en = 1'b0;
        data_in = 16'h0001;
        tick(4);
        nvec++; if (data_out !== 1'b1) begin nerr++; $display("FAIL rmid_sel0_hi: got %b want 1", data_out); end
        data_in = 16'hFFFE;
        tick(4);
        nvec++; if (data_out !== 1'b0) begin nerr++; $display("FAIL rmid_sel0_lo: got %b want 0", data_out); end
    endtask

    initial begin
        rst_n = 1'b0;
        config_en = 1'b0;
        config_in = 1'b0;
        config_latch = 1'b0;
        data_in = 16'h0000;
        data_valid_in = 1'b0;
        #1;
        test_reset();
        test_load_commit();
        test_commit_streaming();
        test_chain();
        test_parity();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/multiplexer_io_ic_pipe.md
# multiplexer_io_ic_pipe

Parametrised, optionally pipelined N:1 IO interconnect multiplexer whose selector is loaded through the fabric's serial configuration chain. It sits in each IO tile between the IO pads/routing tracks and the tile's interconnect input, replacing the fixed 4:1 combinational mux. Configuration is shifted into a shadow register and committed atomically, so the routing never glitches mid-load.

## Interface
- N_INPUTS, 16, number of data inputs; power of two, ≥ 2.
- PIPELINED, 1, 1 = register after every tree level; 0 = purely combinational data path.
- SEL_W (localparam), log2(N_INPUTS), selector width = tree depth L.
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  N_INPUTS  candidate signals.
- data_valid_in  in  1  qualifies data_in.
- data_out  out  1  selected signal.
- data_valid_out  out  1  data_valid_in delayed to match data_out.
- config_en  in  1  shift enable for the config chain.
- config_in  in  1  serial config bit from upstream tile.
- config_out  out  1  serial config bit to downstream tile.
- config_latch  in  1  commit shadow register to the active selector.
- config_err  out  1  sticky parity error (constant 0 without parity).

## Operation
- Shadow register CW bits (CW = SEL_W, or SEL_W+1 with parity). When config_en=1: shadow <= {shadow[CW-2:0], config_in}; config_out = shadow[CW-1] (combinational from register). Selector loaded MSB first; parity bit, when present, shifted last.
- Commit: config_latch=1 and config_en=0 in the same cycle → active_sel <= shadow selector field. config_latch with config_en=1 is ignored (shift wins).
- Tree: L = SEL_W levels. Level 1 halves data_in using active_sel[SEL_W-1] (upper half when 1); level k uses sel bit [SEL_W-k]; last level uses bit 0. data_out = data_in[active_sel] when combinational.
- PIPELINED=1: each level registers its output vector together with the remaining (unused) selector bits and a valid bit, so every sample completes with the selector captured when it entered level 1. A commit never mixes old and new selector bits within one sample.
- data_valid_out does not gate data_out; data passes regardless, valid is advisory.
- Reset (asserted anytime, including mid-shift or mid-pipeline): shadow=0, active_sel=0, all pipeline data/valid/sel registers=0, data_out=0, data_valid_out=0, config_out=0, config_err=0. Partially shifted config is discarded.

## Timing
- PIPELINED=1: latency L cycles; data_in sampled at edge t appears on data_out after edge t+L-1 (registered output). Throughput 1 sample/cycle.
- PIPELINED=0: latency 0; data_out, data_valid_out combinational from data_in, data_valid_in, active_sel.
- Commit at edge t: samples registered into level 1 at edge t+1 onward use the new selector; the first new-selector output appears after edge t+L.
- Shift: CW cycles with config_en=1 load a full word; config_out presents the old MSB first, one bit per enabled cycle.

## Configuration
- MUX_IO_IC_PARITY_EN defined: CW = SEL_W+1; LSB of shadow is an even-parity bit (XOR of all CW bits must be 0). On commit with bad parity: active_sel unchanged, config_err <= 1. On commit with good parity: active_sel updated, config_err <= 0. config_err otherwise holds (sticky).
- Undefined: CW = SEL_W, no parity check, config_err tied 0, every commit accepted.

## Structure
- Package mux_io_ic_pkg: clog2 helper function, chain-length computation (CW from SEL_W and parity macro), reset constants.
- Sub-module mux_io_ic_level: one tree level, parameters IN_W and REGISTERED; halves its input vector by one selector bit, optionally registers data, remaining selector bits and valid. Top instantiates L of them in a generate loop plus the shadow/active config logic.

## Test plan
- Reset: hold rst_n=0 with random inputs → data_out=0, data_valid_out=0, config_out=0, config_err=0; release → active_sel=0 routes data_in[0].
- Load/commit, N_INPUTS=16, PIPELINED=1: shift 4'b1011 (+ parity 1 if enabled), pulse latch, drive data_in=16'h0800 with valid → data_out=1, data_valid_out=1 exactly 4 cycles after input.
- Commit during streaming: selector 3 → 12 while data_in toggles bits 3/12 in alternating patterns → each output sample matches the selector captured at level-1 entry, no mixed-bit glitch.
- Chain pass-through: shift 2×CW bits with config_en=1 → config_out reproduces the first CW bits, delayed CW cycles; latch with config_en=1 is ignored.
- Parity (macro on): commit word with flipped parity bit → active_sel unchanged, config_err=1; next good commit → config_err=0, new selector active.
- Reset mid-shift and mid-pipeline (PIPELINED=1, after 2 of 4 bits) → all registers cleared asynchronously, fresh full load required.
